uart_sw_cmd_ctrl: RTL and testbench



---
 rtl/uart_sw_pkg.sv | 57 +++++
 rtl/uart_sw_cmd_ctrl_if.sv | 20 ++
 rtl/uart_sw_fmt.sv | 130 +++++++++++++
 rtl/uart_sw_cmd_ctrl.sv | 92 +++++++++
 tb/tb_uart_sw_cmd_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sw_pkg.sv
// Shared ASCII constants, command decode and formatter state encoding for the
// stopwatch UART command/report controller.
package uart_sw_pkg;

  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_G_UP = 8'h47;
  localparam logic [7:0] ASCII_G_LO = 8'h67;
  localparam logic [7:0] ASCII_P_UP = 8'h50;
  localparam logic [7:0] ASCII_P_LO = 8'h70;
  localparam logic [7:0] ASCII_U_UP = 8'h55;
  localparam logic [7:0] ASCII_U_LO = 8'h75;
  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_LF    = 8'h0a;
  localparam logic [7:0] ASCII_QMARK = 8'h3f;
  localparam logic [3:0] ASCII_DIGIT_HI = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SEND_DIG,
    ST_SEND_SEP,
    ST_SEND_CR,
    ST_SEND_LF,
    ST_DONE
  } fmt_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_GO,
    CMD_PAUSE,
    CMD_DIR,
    CMD_REPORT,
    CMD_AUTO
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c = CMD_NONE;
    case (b)
      ASCII_C_UP, ASCII_C_LO: c = CMD_CLR;
      ASCII_G_UP, ASCII_G_LO: c = CMD_GO;
      ASCII_P_UP, ASCII_P_LO: c = CMD_PAUSE;
      ASCII_U_UP, ASCII_U_LO: c = CMD_DIR;
      ASCII_R_UP, ASCII_R_LO: c = CMD_REPORT;
      ASCII_A_UP, ASCII_A_LO: c = CMD_AUTO;
      default:                c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_sw_cmd_ctrl_if.sv
// UART FIFO side of the stopwatch controller: show-ahead rx head with pop
// strobe, tx byte with push strobe and full backpressure.
interface uart_sw_cmd_ctrl_if;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] wr_data;

    modport master (
        input  rd_data, rx_empty, tx_full,
        output rd_uart, wr_uart, wr_data
    );

    modport slave (
        output rd_data, rx_empty, tx_full,
        input  rd_uart, wr_uart, wr_data
    );
endinterface

// File: rtl/uart_sw_fmt.sv
// Report sequencer: snapshots the BCD time and streams it as ASCII digits,
// separators and optional CR/LF through the tx FIFO handshake.
module uart_sw_fmt
    import uart_sw_pkg::*;
#(
    parameter int                  DIGITS    = 7,
    parameter logic [8*DIGITS-1:0] SEP_CHARS = 56'h00_3a_00_3a_00_2e_00,
    parameter int                  TERM_CRLF = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);

    fmt_state_t      state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            pending, pending_nxt;
    logic            busy_nxt;
    logic [3:0]      snap [DIGITS];
    logic [7:0]      sep_tab [DIGITS];
    logic [3:0]      cur_digit;

    for (genvar i = 0; i < DIGITS; i++) begin : g_sep
        assign sep_tab[i] = SEP_CHARS[8*i +: 8];
    end

    assign cur_digit = snap[idx];

    // NOTE: snapshot is pure datapath, always written in SNAP before any
    // read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_SNAP) begin
            for (int i = 0; i < DIGITS; i++) begin
                snap[i] <= digits[4*i +: 4];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            pending <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
            busy    <= busy_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        busy_nxt    = busy;
        wr_uart     = 1'b0;
        wr_data     = 8'h00;

        // One request may queue behind the running report; DONE consumes it.
        if (req && state != ST_IDLE && state != ST_DONE) begin
            pending_nxt = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (req) state_nxt = ST_SNAP;
            end
            ST_SNAP: begin
                idx_nxt   = IDX_TOP;
                busy_nxt  = 1'b1;
                state_nxt = ST_SEND_DIG;
            end
            ST_SEND_DIG: begin
                wr_uart = ~tx_full;
                wr_data = (cur_digit <= 4'd9) ? {ASCII_DIGIT_HI, cur_digit} : ASCII_QMARK;
                if (!tx_full) begin
                    if (idx != '0) begin
                        if (sep_tab[idx] != 8'h00) state_nxt = ST_SEND_SEP;
                        else                       idx_nxt   = idx - 1'b1;
                    end else begin
                        state_nxt = (TERM_CRLF != 0) ? ST_SEND_CR : ST_DONE;
                    end
                end
            end
            ST_SEND_SEP: begin
                wr_uart = ~tx_full;
                wr_data = sep_tab[idx];
                if (!tx_full) begin
                    idx_nxt   = idx - 1'b1;
                    state_nxt = ST_SEND_DIG;
                end
            end
            ST_SEND_CR: begin
                wr_uart = ~tx_full;
                wr_data = ASCII_CR;
                if (!tx_full) state_nxt = ST_SEND_LF;
            end
            ST_SEND_LF: begin
                wr_uart = ~tx_full;
                wr_data = ASCII_LF;
                if (!tx_full) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy_nxt = 1'b0;
                if (pending || req) begin
                    pending_nxt = 1'b0;
                    state_nxt   = ST_SNAP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_sw_cmd_ctrl.sv
// UART command decoder and report controller for the stopwatch.
// Optional SW_AUTO_REPORT_EN adds a tick-driven periodic report toggled by 'A'.
module uart_sw_cmd_ctrl
    import uart_sw_pkg::*;
#(
    parameter int                  DIGITS    = 7,
    parameter logic [8*DIGITS-1:0] SEP_CHARS = 56'h00_3a_00_3a_00_2e_00,
    parameter int                  TERM_CRLF = 1,
    parameter int                  AUTO_DIV  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_sw_cmd_ctrl_if.master  bus,
    input  logic [4*DIGITS-1:0] digits,
    input  logic                tick,
    output logic                up,
    output logic                go,
    output logic                clr,
    output logic                busy
);

    logic pop;
    cmd_t cmd;
    logic report_req;

    // Every non-empty cycle pops; the show-ahead head is decoded in place.
    assign pop         = ~bus.rx_empty;
    assign bus.rd_uart = pop;
    assign cmd         = pop ? decode_cmd(bus.rd_data) : CMD_NONE;
    assign clr         = (cmd == CMD_CLR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up <= 1'b1;
            go <= 1'b0;
        end else begin
            case (cmd)
                CMD_CLR:   up <= 1'b1;
                CMD_DIR:   up <= ~up;
                CMD_GO:    go <= 1'b1;
                CMD_PAUSE: go <= 1'b0;
                default:   ;
            endcase
        end
    end

`ifdef SW_AUTO_REPORT_EN
    localparam int CW = $clog2(AUTO_DIV + 1);

    logic          auto_en;
    logic [CW-1:0] auto_cnt;
    logic          auto_hit;

    // A toggle in the same cycle as a tick takes priority over the count.
    assign auto_hit = auto_en && tick && (cmd != CMD_AUTO) &&
                      (auto_cnt == CW'(AUTO_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_en  <= 1'b0;
            auto_cnt <= '0;
        end else if (cmd == CMD_AUTO) begin
            auto_en <= ~auto_en;
            if (auto_en) auto_cnt <= '0;
        end else if (auto_en && tick) begin
            auto_cnt <= auto_hit ? '0 : auto_cnt + 1'b1;
        end
    end

    assign report_req = (cmd == CMD_REPORT) || auto_hit;
`else
    logic unused_tick;
    assign unused_tick = tick & (AUTO_DIV > 0);
    assign report_req  = (cmd == CMD_REPORT);
`endif

    uart_sw_fmt #(
        .DIGITS    (DIGITS),
        .SEP_CHARS (SEP_CHARS),
        .TERM_CRLF (TERM_CRLF)
    ) u_fmt (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (report_req),
        .digits  (digits),
        .tx_full (bus.tx_full),
        .wr_uart (bus.wr_uart),
        .wr_data (bus.wr_data),
        .busy    (busy)
    );

endmodule

// File: tb/tb_uart_sw_cmd_ctrl.sv
// Directed plus randomized bench for uart_sw_cmd_ctrl with a queue-based
// model of the ASCII report line.
module tb_uart_sw_cmd_ctrl;

    localparam int DIGITS = 7;
    localparam logic [8*DIGITS-1:0] SEP = 56'h00_3a_00_3a_00_2e_00;

    typedef logic [7:0] bq_t [$];

    logic clk;
    logic rst_n;
    logic [4*DIGITS-1:0] digits;
    logic tick;
    logic up, go, clr, busy;

    uart_sw_cmd_ctrl_if bus();

    uart_sw_cmd_ctrl #(
        .DIGITS    (DIGITS),
        .SEP_CHARS (SEP),
        .TERM_CRLF (1),
        .AUTO_DIV  (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .digits (digits),
        .tick   (tick),
        .up     (up),
        .go     (go),
        .clr    (clr),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   clr_cnt = 0;
    int   busy_low = 0;
    bq_t  got;
    int   got_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.wr_uart) begin
            got.push_back(bus.wr_data);
            got_cyc.push_back(cyc);
            if (!busy) busy_low++;
        end
        if (clr) clr_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic bq_t model_report(input logic [4*DIGITS-1:0] d);
        bq_t q;
        logic [3:0] n;
        logic [7:0] s;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            n = d[4*i +: 4];
            q.push_back((n <= 4'd9) ? (8'h30 + 8'(n)) : 8'h3f);
            s = SEP[8*i +: 8];
            if (i > 0 && s != 8'h00) q.push_back(s);
        end
        q.push_back(8'h0d);
        q.push_back(8'h0a);
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte for exactly one cycle; returns at posedge+1 after the pop.
    task automatic push(input logic [7:0] b, output int pop_cyc);
        bus.rd_data  = b;
        bus.rx_empty = 1'b0;
        @(negedge clk);
        pop_cyc = cyc;
        check("rd_uart_pop", bus.rd_uart, 1'b1);
        @(posedge clk);
        #1;
        bus.rx_empty = 1'b1;
    endtask

    task automatic wait_bytes(input int n, input int limit, input bit rand_bp);
        int k;
        k = 0;
        while (got.size() < n && k < limit) begin
            if (rand_bp) bus.tx_full = ($urandom_range(0, 3) == 0);
            step();
            k++;
        end
        bus.tx_full = 1'b0;
        repeat (8) step();
    endtask

    task automatic compare_report(input string tag, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
        end
    endtask

    initial begin
        int   t;
        int   dummy;
        int   clr_before;
        bq_t  exp;
        bq_t  exp2;
        logic [4*DIGITS-1:0] d1, d2;

        rst_n        = 1'b0;
        bus.rx_empty = 1'b1;
        bus.rd_data  = 8'h00;
        bus.tx_full  = 1'b0;
        tick         = 1'b0;
        digits       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_up", up, 1'b1);
        check("rst_go", go, 1'b0);
        check("rst_clr", clr, 1'b0);
        check("rst_rd_uart", bus.rd_uart, 1'b0);
        check("rst_wr_uart", bus.wr_uart, 1'b0);
        check("rst_wr_data", bus.wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();

        // Direction and run commands, mixed case.
        push("G", dummy);
        check("go_after_G", go, 1'b1);
        check("up_after_G", up, 1'b1);
        push("u", dummy);
        check("up_after_u", up, 1'b0);
        check("go_after_u", go, 1'b1);
        push("x", dummy);
        check("ignored_byte_up", up, 1'b0);
        check("no_clr_yet", clr_cnt, 0);

        // Plain report: latency, content, back-to-back bytes, busy coverage.
        digits = 28'h1234567;
        got.delete(); got_cyc.delete(); busy_low = 0;
        push("R", t);
        wait_bytes(12, 60, 1'b0);
        compare_report("rpt", model_report(28'h1234567));
        if (got.size() == 12) begin
            check("rpt_latency", got_cyc[0], t + 2);
            check("rpt_consec", got_cyc[11] - got_cyc[0], 11);
        end
        check("rpt_busy", busy_low, 0);
        check("idle_busy", busy, 1'b0);

        // Backpressure on the first separator.
        got.delete(); got_cyc.delete();
        push("r", dummy);
        for (int k = 0; k < 40 && got.size() != 2; k++) step();
        bus.tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_wr_uart", bus.wr_uart, 1'b0);
            check("bp_wr_data", bus.wr_data, 8'h3a);
            check("bp_busy", busy, 1'b1);
            step();
        end
        bus.tx_full = 1'b0;
        wait_bytes(12, 60, 1'b0);
        compare_report("bp_rpt", model_report(28'h1234567));

        // Three requests back-to-back, clear mid-report, snapshot isolation.
        d1 = 28'($urandom());
        d2 = 28'($urandom());
        digits = d1;
        got.delete(); got_cyc.delete();
        push("R", dummy);
        push("R", dummy);
        push("R", dummy);
        digits = d2;
        repeat (3) step();
        clr_before = clr_cnt;
        push("c", dummy);
        check("mid_clr_pulse", clr_cnt - clr_before, 1);
        check("mid_clr_up", up, 1'b1);
        wait_bytes(24, 120, 1'b0);
        exp  = model_report(d1);
        exp2 = model_report(d2);
        foreach (exp2[i]) exp.push_back(exp2[i]);
        compare_report("rrr", exp);

        // Explicit non-BCD digit.
        digits = 28'h12b4567;
        got.delete(); got_cyc.delete();
        push("R", dummy);
        wait_bytes(12, 60, 1'b0);
        compare_report("qmark", model_report(28'h12b4567));
        if (got.size() > 3) check("qmark_pos", got[3], 8'h3f);

        // Random digits under random backpressure.
        for (int n = 0; n < 4; n++) begin
            d1 = 28'($urandom());
            digits = d1;
            got.delete(); got_cyc.delete();
            push(($urandom_range(0, 1) == 0) ? 8'h52 : 8'h72, dummy);
            wait_bytes(12, 200, 1'b1);
            compare_report($sformatf("rand%0d", n), model_report(d1));
        end

        // Auto report: 7 ticks with AUTO_DIV=3.
        d1 = 28'h0098765;
        digits = d1;
        got.delete(); got_cyc.delete();
        push("A", dummy);
        for (int k = 0; k < 7; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (24) step();
        end
        exp.delete();
`ifdef SW_AUTO_REPORT_EN
        exp  = model_report(d1);
        exp2 = model_report(d1);
        foreach (exp2[i]) exp.push_back(exp2[i]);
`endif
        compare_report("auto", exp);
        got.delete(); got_cyc.delete();
        push("a", dummy);
        for (int k = 0; k < 7; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (24) step();
        end
        check("auto_off_len", got.size(), 0);

        // Reset in the middle of a report.
        got.delete(); got_cyc.delete();
        check("go_before_rst", go, 1'b1);
        push("R", dummy);
        for (int k = 0; k < 40 && got.size() != 4; k++) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_uart", bus.wr_uart, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_go", go, 1'b0);
        check("rst_mid_up", up, 1'b1);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        check("rst_no_resume", got.size(), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
